// File: rtl/icache_fetch_pkg.sv
// Shared fetch-pipeline constants: widths, line geometry, FSM encoding and
// the idle instruction code.
package icache_fetch_pkg;

  localparam int unsigned INST_W         = 16;
  localparam int unsigned ADDR_W         = 16;
  localparam int unsigned WORDS_PER_LINE = 4;
  localparam int unsigned OFF_W          = 2;

  localparam logic [INST_W-1:0] INIT_CODE_DEFAULT = 16'h0000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:3], 3'b000};
  endfunction

endpackage

// File: rtl/icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Only the valid vector is reset; tags and data are plain flops.
module icache_array
  import icache_fetch_pkg::*;
#(
  parameter int unsigned NUM_LINES = 8,
  parameter int unsigned IW        = 3,
  parameter int unsigned TW        = 10
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [IW-1:0]                          i_rd_idx,
  output logic                                   o_rd_valid,
  output logic [TW-1:0]                          o_rd_tag,
  output logic [WORDS_PER_LINE-1:0][INST_W-1:0]  o_rd_words,
  input  logic                                   i_wr_en,
  input  logic [IW-1:0]                          i_wr_idx,
  input  logic [OFF_W-1:0]                       i_wr_word,
  input  logic [INST_W-1:0]                      i_wr_data,
  input  logic                                   i_tag_wr,
  input  logic [TW-1:0]                          i_wr_tag
);

  logic [NUM_LINES-1:0]                  r_valid;
  logic [TW-1:0]                         r_tag  [NUM_LINES];
  logic [WORDS_PER_LINE-1:0][INST_W-1:0] r_data [NUM_LINES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (i_tag_wr) begin
      r_valid[i_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data[i_wr_idx][i_wr_word] <= i_wr_data;
    end
    if (i_tag_wr) begin
      r_tag[i_wr_idx] <= i_wr_tag;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_words = r_data[i_rd_idx];

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped instruction cache: 1-cycle hits, 4-beat line refill on miss.
// Outputs in LOOKUP/RESP are combinational from the registered address.
module icache_fetch
  import icache_fetch_pkg::*;
#(
  parameter int unsigned       NUM_LINES = 8,
  parameter logic [INST_W-1:0] INIT_CODE = INIT_CODE_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_valid,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               flush,
  output logic               inst_valid,
  output logic [INST_W-1:0]  inst_code,
  output logic               stall,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INST_W-1:0]  mem_rdata,
  output logic [15:0]        miss_count
);

  localparam int unsigned IW = $clog2(NUM_LINES);
  localparam int unsigned TW = ADDR_W - IW - 3;

  logic [2:0]        r_state;
  logic [ADDR_W-1:1] r_addr;
  logic [1:0]        r_beat;
  logic              r_kill;
  logic [15:0]       r_miss_count;
  logic [ADDR_W-1:0] r_mem_addr;

  logic [IW-1:0]                         w_idx;
  logic [TW-1:0]                         w_tag;
  logic [OFF_W-1:0]                      w_off;
  logic                                  w_rd_valid;
  logic [TW-1:0]                         w_rd_tag;
  logic [WORDS_PER_LINE-1:0][INST_W-1:0] w_rd_words;
  logic                                  w_hit, w_lookup, w_miss;
  logic                                  w_hit_out, w_resp_out;
  logic                                  w_wr_en, w_tag_wr;
  logic                                  w_unused_pc_lsb;

  assign w_unused_pc_lsb = pc_addr[0];

  assign w_idx = r_addr[IW+2:3];
  assign w_tag = r_addr[ADDR_W-1:IW+3];
  assign w_off = r_addr[2:1];

  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
  assign w_lookup   = (r_state == S_LOOKUP);
  // flush in LOOKUP overrides both the hit response and the miss/refill
  assign w_miss     = w_lookup && !w_hit && !flush;
  assign w_hit_out  = w_lookup && w_hit && !flush;
  assign w_resp_out = (r_state == S_RESP) && !r_kill && !flush;

  assign inst_valid = w_hit_out || w_resp_out;
  assign inst_code  = inst_valid ? w_rd_words[w_off] : INIT_CODE;
  assign stall      = w_miss || (r_state == S_REQ) || (r_state == S_FILL);
  assign mem_req    = (r_state == S_REQ);
  assign mem_addr   = r_mem_addr;
  assign miss_count = r_miss_count;

  assign w_wr_en  = (r_state == S_FILL) && mem_rvalid;
  assign w_tag_wr = w_wr_en && (r_beat == 2'd3);

  icache_array #(
    .NUM_LINES (NUM_LINES),
    .IW        (IW),
    .TW        (TW)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .i_rd_idx   (w_idx),
    .o_rd_valid (w_rd_valid),
    .o_rd_tag   (w_rd_tag),
    .o_rd_words (w_rd_words),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_idx),
    .i_wr_word  (r_beat),
    .i_wr_data  (mem_rdata),
    .i_tag_wr   (w_tag_wr),
    .i_wr_tag   (w_tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_beat       <= '0;
      r_kill       <= 1'b0;
      r_miss_count <= '0;
      r_mem_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (pc_valid) begin
            r_addr  <= pc_addr[ADDR_W-1:1];
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_miss) begin
            if (r_miss_count != '1) r_miss_count <= r_miss_count + 16'd1;
            r_mem_addr <= line_base({r_addr, 1'b0});
            r_kill     <= 1'b0;
            r_state    <= S_REQ;
          end else if (pc_valid) begin
            r_addr <= pc_addr[ADDR_W-1:1];
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_REQ: begin
          if (flush) r_kill <= 1'b1;
          if (mem_gnt) begin
            r_beat  <= '0;
            r_state <= S_FILL;
          end
        end
        S_FILL: begin
          if (flush) r_kill <= 1'b1;
          if (mem_rvalid) begin
            r_beat <= r_beat + 2'd1;
            if (r_beat == 2'd3) r_state <= S_RESP;
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_fetch.sv
// Self-checking bench for icache_fetch: directed refill/flush/reset sequences,
// a per-cycle vector table for hit streaming, and randomized traffic.
module tb_icache_fetch;

  localparam logic [15:0] INIT = 16'h5EED;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pc_valid = 1'b0;
  logic [15:0] pc_addr = '0;
  logic        flush = 1'b0;
  logic        inst_valid;
  logic [15:0] inst_code;
  logic        stall;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [15:0] mem_rdata = '0;
  logic [15:0] miss_count;

  int total = 0;
  int bad   = 0;

  // Reference cache contents: 8 lines, index = a[5:3], tag = a[15:6]
  bit                 m_valid [8];
  logic [9:0]         m_tag   [8];
  logic [3:0][15:0]   m_data  [8];
  logic [15:0]        m_cnt;

  typedef struct {
    logic        pv;
    logic [15:0] pa;
    logic        fl;
    logic        ev;
    logic [15:0] ec;
    logic        es;
  } vec_t;
  vec_t tbl [9];

  icache_fetch #(
    .NUM_LINES (8),
    .INIT_CODE (INIT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pc_valid   (pc_valid),
    .pc_addr    (pc_addr),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_code  (inst_code),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
    m_cnt = '0;
  endtask

  function automatic logic [15:0] memw(input logic [15:0] a);
    return {a[7:0] ^ 8'hA5, a[15:8] + 8'h3C};
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"},  inst_valid, 0);
    chk({tag, "_code"},   inst_code,  INIT);
    chk({tag, "_stall"},  stall,      0);
    chk({tag, "_req"},    mem_req,    0);
    chk({tag, "_maddr"},  mem_addr,   0);
    chk({tag, "_mcount"}, miss_count, 0);
  endtask

  // One fetch from IDLE; a miss is refilled with the given beats.
  task automatic txn(input logic [15:0] a, input logic [3:0][15:0] beats,
                     input int gdly, input int gap, input int fl_cyc, input bit fl_req);
    int unsigned idx;
    logic [9:0]  tg;
    logic [15:0] la;
    bit          hit, killed;
    int          fc;
    idx = a[5:3];
    tg  = a[15:6];
    la  = {a[15:3], 3'b000};
    hit = m_valid[idx] && (m_tag[idx] == tg);
    pc_valid = 1'b1;
    pc_addr  = a;
    @(negedge clk);
    chk("accept_valid", inst_valid, 0);
    chk("accept_stall", stall, 0);
    tick();
    pc_valid = 1'b0;
    pc_addr  = 16'($urandom);
    @(negedge clk);
    if (hit) begin
      chk("hit_valid", inst_valid, 1);
      chk("hit_code",  inst_code,  m_data[idx][a[2:1]]);
      chk("hit_stall", stall, 0);
      tick();
    end else begin
      chk("miss_stall", stall, 1);
      chk("miss_valid", inst_valid, 0);
      chk("miss_code",  inst_code, INIT);
      tick();
      if (m_cnt != 16'hFFFF) m_cnt++;
      for (int i = 0; i < gdly; i++) begin
        flush = fl_req && (i == 0);
        @(negedge clk);
        chk("req_wait", mem_req, 1);
        chk("req_addr_wait", mem_addr, la);
        chk("req_stall", stall, 1);
        tick();
        flush = 1'b0;
      end
      mem_gnt = 1'b1;
      flush = fl_req && (gdly == 0);
      @(negedge clk);
      chk("req_gnt", mem_req, 1);
      chk("req_addr", mem_addr, la);
      tick();
      mem_gnt = 1'b0;
      flush = 1'b0;
      fc = 0;
      for (int b = 0; b < 4; b++) begin
        for (int g = 0; g < ((b == 0) ? 0 : gap); g++) begin
          mem_rdata = 16'($urandom);
          flush = (fc == fl_cyc);
          @(negedge clk);
          chk("gap_stall", stall, 1);
          chk("gap_req", mem_req, 0);
          chk("gap_valid", inst_valid, 0);
          tick();
          flush = 1'b0;
          fc++;
        end
        mem_rvalid = 1'b1;
        mem_rdata  = beats[b];
        flush = (fc == fl_cyc);
        @(negedge clk);
        chk("beat_stall", stall, 1);
        tick();
        mem_rvalid = 1'b0;
        flush = 1'b0;
        fc++;
      end
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
      m_data[idx]  = beats;
      killed = fl_req || (fl_cyc >= 0 && fl_cyc < fc);
      @(negedge clk);
      chk("resp_valid", inst_valid, killed ? 0 : 1);
      chk("resp_code",  inst_code,  killed ? INIT : beats[a[2:1]]);
      chk("resp_stall", stall, 0);
      tick();
    end
    chk("miss_count", miss_count, m_cnt);
  endtask

  initial begin
    logic [3:0][15:0] bt;
    logic [15:0]      ra;
    logic [15:0]      la;

    tbl[0] = '{1'b1, 16'h0008, 1'b0, 1'b0, INIT,     1'b0};
    tbl[1] = '{1'b1, 16'h000A, 1'b0, 1'b1, 16'hA000, 1'b0};
    tbl[2] = '{1'b1, 16'h000C, 1'b0, 1'b1, 16'hA001, 1'b0};
    tbl[3] = '{1'b1, 16'h000E, 1'b0, 1'b1, 16'hA002, 1'b0};
    tbl[4] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA003, 1'b0};
    tbl[5] = '{1'b1, 16'h000C, 1'b0, 1'b0, INIT,     1'b0};
    tbl[6] = '{1'b1, 16'h000E, 1'b1, 1'b0, INIT,     1'b0};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hA003, 1'b0};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b0, INIT,     1'b0};

    model_clear();
    tick();
    tick();
    chk_reset_outputs("reset");
    reset = 1'b0;
    tick();

    // Cold miss: line 0x0008 filled with A000..A003, word 2 returned
    txn(16'h000C, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 0, 0, -1, 1'b0);
    chk("cold_mcount", miss_count, 1);

    // Hit streaming and LOOKUP flush redirect, one vector per cycle
    for (int i = 0; i < 9; i++) begin
      pc_valid = tbl[i].pv;
      pc_addr  = tbl[i].pa;
      flush    = tbl[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), inst_valid, tbl[i].ev);
      chk($sformatf("vec%0d_code", i),  inst_code,  tbl[i].ec);
      chk($sformatf("vec%0d_stall", i), stall,      tbl[i].es);
      tick();
    end
    pc_valid = 1'b0;
    flush    = 1'b0;
    chk("stream_mcount", miss_count, 1);

    // Conflict miss then re-miss on the evicted line
    txn(16'h004C, {16'hB003, 16'hB002, 16'hB001, 16'hB000}, 0, 0, -1, 1'b0);
    txn(16'h000C, {16'hA003, 16'hA002, 16'hA001, 16'hA000}, 1, 0, -1, 1'b0);
    chk("conflict_mcount", miss_count, 3);

    // Flush in the 2nd FILL cycle: response killed, line still installed
    txn(16'h0010, {16'hC003, 16'hC002, 16'hC001, 16'hC000}, 0, 0, 1, 1'b0);
    txn(16'h0012, {16'h0, 16'h0, 16'h0, 16'h0}, 0, 0, -1, 1'b0);
    chk("flush_mcount", miss_count, 4);

    // Reset after two beats abandons the fill
    pc_valid = 1'b1;
    pc_addr  = 16'h0030;
    tick();
    pc_valid = 1'b0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hD000;
    tick();
    mem_rdata  = 16'hD001;
    tick();
    mem_rvalid = 1'b0;
    chk("midfill_stall", stall, 1);
    reset = 1'b1;
    #1;
    chk_reset_outputs("midfill_rst");
    tick();
    reset = 1'b0;
    model_clear();
    mem_rvalid = 1'b1;
    mem_rdata  = 16'hDEAD;
    @(negedge clk);
    chk("stray_beat_stall", stall, 0);
    chk("stray_beat_valid", inst_valid, 0);
    tick();
    mem_rvalid = 1'b0;
    txn(16'h0030, {16'hE003, 16'hE002, 16'hE001, 16'hE000}, 0, 0, -1, 1'b0);
    chk("rst_refill_mcount", miss_count, 1);

    // Slow grant and gaps between beats
    txn(16'h0056, {16'hF003, 16'hF002, 16'hF001, 16'hF000}, 5, 2, -1, 1'b0);

    // Randomized traffic against the reference cache
    for (int n = 0; n < 150; n++) begin
      ra = 16'($urandom_range(0, 255));
      la = {ra[15:3], 3'b000};
      for (int b = 0; b < 4; b++) bt[b] = memw(la + 16'(2 * b));
      txn(ra, bt, $urandom_range(0, 3), $urandom_range(0, 2),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1,
          ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Direct-mapped instruction cache between the fetch stage PC and the instruction memory port.
- Fetch presents a PC each cycle; the block returns the 16-bit instruction code to fetch/decode one cycle later on a hit.
- On a miss it stalls fetch, refills a 4-word line over a beat-based memory handshake, then delivers the word.
- Fetch holds enable_pc low while stall is high.

Parameters:
- NUM_LINES, 8, number of cache lines; power of 2, minimum 2. Index width IW = log2(NUM_LINES).
- INIT_CODE, 16'h0000, value driven on inst_code during reset and while no valid instruction is output.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- pc_valid  in  1  fetch request valid; accepted only in a cycle where stall=0.
- pc_addr  in  16  byte address of the instruction; bit 0 is ignored.
- flush  in  1  branch redirect (decode sel_pc≠0); kills the pending response.
- inst_valid  out  1  inst_code valid this cycle.
- inst_code  out  16  instruction word (high byte = bits 15:8).
- stall  out  1  cache busy; fetch must hold the PC.
- mem_req  out  1  line refill request; held until mem_gnt.
- mem_addr  out  16  line-aligned refill address, bits 2:0 = 0.
- mem_gnt  in  1  memory accepts the request.
- mem_rvalid  in  1  one refill beat valid.
- mem_rdata  in  16  refill word; beats arrive in order for words 0..3.
- miss_count  out  16  saturating count of misses since reset.

Behaviour:
- Address split: word offset = pc_addr[2:1]; index = pc_addr[IW+2:3]; tag = pc_addr[15:IW+3].
- Storage: per line, a valid bit, a tag, and 4×16-bit words, all in flops.
- Reset (async): clears all valid bits, state = IDLE, stall=0, inst_valid=0, inst_code=INIT_CODE, mem_req=0, mem_addr=0, miss_count=0. Data and tag arrays are not reset.
- Reset asserted mid-fill abandons the fill. No line becomes valid. Memory beats arriving after reset deasserts are ignored while in IDLE.
- States:
  - IDLE: if pc_valid, register the address and go to LOOKUP; else inst_valid=0.
  - LOOKUP: compares the tag of the registered address.
    - Hit and no flush: inst_valid=1, inst_code=word. If pc_valid is high the same cycle, register the new address and stay in LOOKUP, giving back-to-back hits at 1/cycle. Else go to IDLE.
    - Miss: stall=1, inst_valid=0, miss_count+1 (saturates at 16'hFFFF), mem_req=1, mem_addr={addr[15:3],3'b000}, go to REQ.
  - REQ: mem_req held until mem_gnt. On mem_gnt the same cycle, mem_req→0, beat counter=0, go to FILL.
  - FILL: each mem_rvalid writes mem_rdata to word[beat] of the line and increments the beat counter. On the 4th beat, write the tag, set valid, go to RESP. Cycles without mem_rvalid wait indefinitely.
  - RESP: inst_valid=1 with the requested word (read from the filled line), stall=0, go to IDLE. The next request is accepted from the following cycle.
- stall=1 in REQ and FILL. Also stall=1 in LOOKUP on a miss, as a combinational output of the registered compare.
- Flush:
  - In LOOKUP: suppress inst_valid and drop the registered request. If pc_valid is high the same cycle, accept the new PC (the redirect target).
  - In REQ or FILL: mark the response as killed. The fill still completes and installs the line, but RESP drives inst_valid=0.
  - A flush in IDLE or RESP has no effect beyond suppressing the RESP output.
- Valid bit is set only after all 4 beats have been written; a partially filled line never hits.
- inst_code holds INIT_CODE whenever inst_valid=0.
- Latency:
  - Hit: 1 cycle from accept to inst_valid.
  - Miss: 1 (lookup) + grant wait + 4 beats + 1 (RESP).

Decomposition:
- Shared package (pipeline-wide): instruction width (16), address width (16), words per line (4), FSM state encoding for IDLE/LOOKUP/REQ/FILL/RESP, and the INIT_CODE default.
- One sub-module is natural: icache_array. It holds the tag, valid and data storage with an async-reset valid vector. It provides one combinational read port (index → tag, valid, line words) and a write port (word write; tag+valid write).
- The FSM, counters and address split stay in icache_fetch.

Test Plan:
- Cold miss: reset, then pc_addr=16'h000C. Expect miss_count=1 and mem_req with mem_addr=16'h0008, then gnt. Beats 16'hA000, A001, A002, A003 → one cycle after the last beat, inst_valid=1 and inst_code=16'hA002.
- Hit streaming: after the cold miss, pc_addr 16'h0008, 000A, 000C, 000E on consecutive cycles. Expect A000..A003 on 4 consecutive cycles, stall=0 throughout and miss_count still 1.
- Conflict miss: pc_addr=16'h004C (same index, different tag). Expect mem_addr=16'h0048 and a refill. A following request to 16'h000C misses again; miss_count=3.
- Flush during fill: miss on 16'h0010 with flush pulsed in the 2nd FILL cycle. Expect no inst_valid at RESP. A subsequent request to 16'h0012 hits in 1 cycle with the 2nd beat's data.
- Reset mid-fill: assert reset after 2 beats. Outputs are immediately at reset values. Re-requesting the same address misses (miss_count=1) and a full 4-beat refill occurs.
- Grant delay and gaps: hold mem_gnt low for 5 cycles and insert 2 idle cycles between beats. Expect mem_req held stable, stall=1 throughout, and correct word delivered.
